// File: rtl/pdm_decim_pkg.sv
// pdm_decim_pkg -- shared types and helpers for the PDM-to-PCM CIC decimator.
//   PCM_Q      : PCM output width, taken from `PCM_QUANT in def.v
//   CIC_ORDER  : number of integrator / comb stages
//   pdm_step() : maps one PDM bit to its bipolar value (+1 / -1)
`include "def.v"

package pdm_decim_pkg;

  localparam int PCM_Q     = `PCM_QUANT;
  localparam int CIC_ORDER = 3;

  typedef logic signed [1:0] pdm_step_t;

  // A PDM '1' is +1 and a '0' is -1.
  function automatic pdm_step_t pdm_step(input logic b);
    return b ? 2'sd1 : -2'sd1;
  endfunction

endpackage

// File: rtl/def.v
// Shared project definitions.
//   PCM_QUANT : width in bits of the signed PCM samples produced by the
//               decimators. May be overridden on the tool command line.
`ifndef PCM_QUANT
`define PCM_QUANT 16
`endif

// File: rtl/pdm_decim_comb.sv
// cic_comb -- one registered comb (difference) stage of the CIC decimator.
// On every clk where i_valid is high the stage produces
// o_data = i_data - (previous accepted i_data) and remembers i_data.
// o_valid is i_valid delayed by one clk, so a one-clk strobe stays one clk.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears data, delay and valid
//   i_data  : W-bit signed sample in
//   i_valid : qualifies i_data
//   o_data  : W-bit signed difference, held between strobes
//   o_valid : one-clk strobe marking a new o_data
module cic_comb #(
  parameter int W = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] i_data,
  input  logic                i_valid,
  output logic signed [W-1:0] o_data,
  output logic                o_valid
);

  logic signed [W-1:0] r_dly;
  logic signed [W-1:0] r_out;
  logic                r_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly <= '0;
      r_out <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= i_valid;
      if (i_valid) begin
        // Modular subtraction: correct even when the integrators have wrapped.
        r_out <= i_data - r_dly;
        r_dly <= i_data;
      end
    end
  end

  assign o_data  = r_out;
  assign o_valid = r_vld;

endmodule

// File: rtl/pdm_decim.sv
// pdm_decim -- 3rd-order CIC decimator turning a 1-bit PDM stream into PCM.
// Decimation ratio R = 2^DECIM_LOG2, differential delay 1.
// Integrators run at the accepted-bit rate; every R accepted bits the third
// integrator is captured and pushed through three registered comb stages.
// pcm_valid pulses 4 clks after the edge that accepted the R-th bit.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (wins over pdm_valid)
//   pdm       : PDM bit, 1 = +1, 0 = -1
//   pdm_valid : qualifies pdm; one bit accepted per qualified clk
//   pcm_out   : signed `PCM_QUANT-bit sample, held until the next pulse
//   pcm_valid : one-clk strobe marking a new pcm_out
// Build option: define PDM_DECIM_SAT_EN to saturate the shifted result to the
// PCM range; without it the low `PCM_QUANT bits are taken (+full-scale wraps).
`include "def.v"

module pdm_decim
  import pdm_decim_pkg::*;
#(
  parameter int DECIM_LOG2 = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pdm,
  input  logic                         pdm_valid,
  output logic signed [`PCM_QUANT-1:0] pcm_out,
  output logic                         pcm_valid
);

  localparam int          Q = PCM_Q;
  localparam int          W = CIC_ORDER * DECIM_LOG2 + 2;
  localparam int          S = CIC_ORDER * DECIM_LOG2 - (Q - 1);
  localparam int unsigned R = 32'd1 << DECIM_LOG2;

  localparam logic [DECIM_LOG2-1:0] CNT_LAST = DECIM_LOG2'(R - 1);

  generate
    if (DECIM_LOG2 < 1 || S < 0) begin : g_bad_cfg
      $fatal(1, "pdm_decim: DECIM_LOG2 must be >= 1 and 3*DECIM_LOG2 >= PCM_QUANT-1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Integrators and decimation counter (advance only on accepted bits)
  // ---------------------------------------------------------------------------
  logic signed [W-1:0]     w_step;
  logic                    w_dec_evt;

  logic signed [W-1:0]     r_int1;
  logic signed [W-1:0]     r_int2;
  logic signed [W-1:0]     r_int3;
  logic [DECIM_LOG2-1:0]   r_cnt;
  logic                    r_dec_evt;

  assign w_step    = W'(pdm_step(pdm));
  assign w_dec_evt = pdm_valid && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int1    <= '0;
      r_int2    <= '0;
      r_int3    <= '0;
      r_cnt     <= '0;
      r_dec_evt <= 1'b0;
    end else begin
      r_dec_evt <= w_dec_evt;
      if (pdm_valid) begin
        // Each stage sums the previous stage's registered value, so the
        // cascade is fully pipelined; wrap modulo 2^W is intentional.
        r_int1 <= r_int1 + w_step;
        r_int2 <= r_int2 + r_int1;
        r_int3 <= r_int3 + r_int2;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture register: takes the third integrator the clk after the event
  // ---------------------------------------------------------------------------
  logic signed [W-1:0] r_cap;
  logic                r_cap_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap     <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= r_dec_evt;
      if (r_dec_evt) begin
        r_cap <= r_int3;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comb section: three registered difference stages
  // ---------------------------------------------------------------------------
  logic signed [W-1:0] w_c1;
  logic signed [W-1:0] w_c2;
  logic signed [W-1:0] w_c3;
  logic                w_v1;
  logic                w_v2;
  logic                w_v3;

  cic_comb #(.W(W)) u_comb1 (
    .clk     (clk),
    .rst     (rst),
    .i_data  (r_cap),
    .i_valid (r_cap_vld),
    .o_data  (w_c1),
    .o_valid (w_v1)
  );

  cic_comb #(.W(W)) u_comb2 (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_c1),
    .i_valid (w_v1),
    .o_data  (w_c2),
    .o_valid (w_v2)
  );

  cic_comb #(.W(W)) u_comb3 (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_c2),
    .i_valid (w_v2),
    .o_data  (w_c3),
    .o_valid (w_v3)
  );

  // ---------------------------------------------------------------------------
  // Output scaling: +R^3 maps to +2^(Q-1). The last comb register holds its
  // value between strobes, so pcm_out is a pure function of it.
  // ---------------------------------------------------------------------------
  assign pcm_valid = w_v3;

`ifdef PDM_DECIM_SAT_EN
  localparam logic signed [W-1:0] P_MAX = W'((64'sd1 <<< (Q - 1)) - 64'sd1);
  localparam logic signed [W-1:0] P_MIN = ~P_MAX;

  logic signed [W-1:0] w_shift;

  always_comb begin
    w_shift = w_c3 >>> S;
    pcm_out = Q'(w_shift);
    if (w_shift > P_MAX) begin
      pcm_out = Q'(P_MAX);
    end else if (w_shift < P_MIN) begin
      pcm_out = Q'(P_MIN);
    end
  end
`else
  assign pcm_out = Q'(w_c3 >>> S);
`endif

endmodule

// File: tb/tb_pdm_decim.sv
// tb_pdm_decim -- directed self-checking bench for pdm_decim (DECIM_LOG2=8,
// PCM_QUANT=16). Expected values are hand-derived:
//   constant +1 : sample1 = C(256,3)>>9 = 5397, sample2 = 13948160>>9 = 27242,
//                 samples >= 3 reach +2^24 >> 9 = 32768 (sat 32767 / wrap -32768)
//   constant -1 : -32768
//   1,0,1,0     : 0
//   1,0,0,0     : -2^23 >> 9 = -16384
`ifndef PCM_QUANT
`define PCM_QUANT 16
`endif

module tb_pdm_decim;

  localparam int L = 8;
  localparam int R = 256;
  localparam int Q = `PCM_QUANT;

`ifdef PDM_DECIM_SAT_EN
  localparam int FS_POS = 32767;
`else
  localparam int FS_POS = -32768;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                pdm;
  logic                pdm_valid;
  logic signed [Q-1:0] pcm_out;
  logic                pcm_valid;

  int checks = 0;
  int errors = 0;

  int mode    = 0;
  int vsp     = 1;
  int clk_idx = 0;
  int acc     = 0;

  always #5 clk = ~clk;

  pdm_decim #(.DECIM_LOG2(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .pdm       (pdm),
    .pdm_valid (pdm_valid),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic pat(input int m, input int a);
    case (m)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (a % 2) == 0;
      default: return (a % 4) == 0;
    endcase
  endfunction

  // Drive inputs for the next edge, take the edge, settle 1 time unit.
  task automatic tick();
    pdm_valid = (clk_idx % vsp) == 0;
    pdm       = pat(mode, acc);
    if (pdm_valid && !rst) acc++;
    clk_idx++;
    @(posedge clk);
    #1;
  endtask

  // Tick until pcm_valid is seen (bounded); n = ticks taken.
  task automatic wait_pulse(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pcm_valid && n < 1000);
    chk({tag, "_arrive"}, 32'(pcm_valid), 1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    clk_idx = 0;
    tick();
    tick();
    chk("rst_valid", 32'(pcm_valid), 0);
    chk("rst_out", pcm_out, 0);
    rst     = 1'b0;
    clk_idx = 0;
    acc     = 0;
  endtask

  task automatic run(input string tag, input int m, input int v, input int settled);
    int n;
    mode = m;
    vsp  = v;
    do_reset();
    for (int s = 1; s <= 5; s++) begin
      wait_pulse(tag, n);
      if (s == 1) chk({tag, "_latency"}, n, (R - 1) * v + 5);
      else        chk({tag, "_gap"}, n, R * v);
      if (m == 0 && s == 1) chk({tag, "_s1"}, pcm_out, 5397);
      if (m == 0 && s == 2) chk({tag, "_s2"}, pcm_out, 27242);
      if (s >= 4)           chk({tag, "_val"}, pcm_out, settled);
    end
    for (int k = 0; k < 10; k++) tick();
    chk({tag, "_hold_out"}, pcm_out, settled);
    chk({tag, "_hold_vld"}, 32'(pcm_valid), 0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    pdm       = 1'b0;
    pdm_valid = 1'b0;

    run("ones",     0, 1, FS_POS);
    run("zeros",    1, 1, -32768);
    run("alt",      2, 1, 0);
    run("quarter",  3, 1, -16384);
    run("sparse",   0, 3, FS_POS);

    // Reset arriving 2 clks after a decimation event discards that sample.
    mode = 0;
    vsp  = 1;
    do_reset();
    wait_pulse("rs_first", n);
    chk("rs_first_val", pcm_out, 5397);
    for (int k = 0; k < R - 4; k++) tick();   // second event edge just taken
    tick();
    rst = 1'b1;
    tick();
    chk("rs_vld", 32'(pcm_valid), 0);
    chk("rs_out", pcm_out, 0);
    rst     = 1'b0;
    clk_idx = 0;
    acc     = 0;
    wait_pulse("rs_next", n);
    chk("rs_next_latency", n, R + 4);
    chk("rs_next_val", pcm_out, 5397);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
